hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard handler.
- Adds a register scoreboard for multi-cycle execution units (mul/div and their successors) on top of the existing single-cycle forwarding and stall logic.
- Sits beside the decode stage. Records each long-latency issue, counts it down to writeback, and stalls F/D (flushing E) while a D-stage instruction reads, overwrites, or targets a busy unit.
- A combinational base-hazard stall (load-use, branch) is ORed in, so this block becomes the single stall/flush source.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired and never tracked.
- REG_W, 5, register index width; must satisfy 2**REG_W >= NUM_REGS.
- NUM_UNITS, 2, number of non-pipelined multi-cycle units.
- UNIT_W, 1, unit index width; must satisfy 2**UNIT_W >= NUM_UNITS.
- LAT_W, 6, latency/countdown width; maximum latency is 2**LAT_W-1.
- PERF_W, 32, stall performance counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rs_d_i  in  REG_W  D-stage source A
- rt_d_i  in  REG_W  D-stage source B
- rs_used_d_i  in  1  source A actually read
- rt_used_d_i  in  1  source B actually read
- issue_d_i  in  1  D instruction is a multi-cycle op
- issue_unit_d_i  in  UNIT_W  target unit
- issue_lat_d_i  in  LAT_W  cycles from issue edge to writeback
- issue_dst_d_i  in  REG_W  destination register
- base_stall_i  in  1  load-use/branch stall from the single-cycle hazard logic
- flush_d_i  in  1  branch mispredict/jump flush of D
- stall_f_o  out  1  freeze PC
- stall_d_o  out  1  freeze IF/ID
- flush_e_o  out  1  bubble into E
- pend_o  out  NUM_REGS  per-register pending vector
- unit_busy_o  out  NUM_UNITS  per-unit busy vector
- stall_cnt_o  out  PERF_W  saturating count of scoreboard-caused stall cycles

Behaviour:
- State:
  - cnt[r] (LAT_W bits) per register r = 1..NUM_REGS-1.
  - ucnt[u] (LAT_W bits) per unit.
  - pend[r] = (cnt[r] != 0); busy[u] = (ucnt[u] != 0).
  - pend[0] is constant 0.
- Reset (async, rst_ni=0): all cnt, ucnt and stall_cnt_o cleared to 0. Consequently stall_f_o=stall_d_o=flush_e_o=0 (given base_stall_i=0) and pend_o=unit_busy_o=0. Reset mid-operation abandons all in-flight tracking.
- sb_stall (combinational) is the OR of:
  - RAW: rs_used_d_i && pend[rs_d_i], or rt_used_d_i && pend[rt_d_i].
  - WAW: issue_d_i && pend[issue_dst_d_i].
  - Structural: issue_d_i && busy[issue_unit_d_i].
- Outputs: stall_d_o = stall_f_o = flush_e_o = sb_stall || base_stall_i.
- Issue accept (per clock edge): issue_d_i && !stall_d_o && !flush_d_i && issue_lat_d_i != 0.
  - On accept: cnt[dst] <= issue_lat_d_i (if dst != 0); ucnt[unit] <= issue_lat_d_i.
  - A latency of 0 means a single-cycle op and is not tracked.
  - A unit index >= NUM_UNITS is ignored for busy tracking.
- Countdown: every cycle, each non-zero cnt/ucnt decrements by 1. The entry not written by an accepting issue this cycle decrements; the issue write wins over the decrement for the same entry.
- Timing: cnt reaches 0 on the edge that writes back. A reader in D is released in the cycle pend drops and obtains the value via the regfile write-through path. Latency from the issue edge to D release is L cycles.
- Simultaneous events:
  - Issue and expiry of a different register in the same cycle are independent.
  - Issue to a register whose cnt==1 is blocked by WAW this cycle and accepted next cycle.
- flush_d_i has priority over issue; no scoreboard update occurs.
- stall_cnt_o increments on each cycle with sb_stall=1 and saturates at all-ones. Cycles with only base_stall_i=1 are not counted.

Decomposition:
- Shared package hazard_pkg: REG_W and LAT_W default constants; typedefs reg_idx_t, lat_t, unit_idx_t.
- One sub-module, sb_counter: a LAT_W-bit countdown with load-priority and a nonzero flag, instantiated per register and per unit.
- The stall OR and the perf counter remain in the top module.

Test Plan:
- Reset: hold rst_ni=0 with issue_d_i=1 -> all outputs 0. Release rst_ni -> pend_o=0 and stall_cnt_o=0.
- RAW: issue unit 0, dst=8, lat=4 at cycle 0. Then D reads rs=8 with rs_used=1 -> stall_d_o=1 for cycles 1-3, 0 at cycle 4. stall_cnt_o=3.
- Structural/WAW: issue unit 1, dst=5, lat=6; next issue to unit 1, dst=9 -> stalls until ucnt=0. A separate issue to dst=5 on unit 0 -> WAW stall until pend_o[5]=0.
- Flush and zero cases: issue with flush_d_i=1 -> pend_o unchanged. Issue with lat=0 or dst=0 -> pend_o stays 0, no stall.
- Base OR: base_stall_i=1 alone -> stall/flush outputs=1 and stall_cnt_o unchanged. Issue during base stall is not accepted.
- Saturation/mid-op reset: preload near max via a long stall (PERF_W=4 build) -> stall_cnt_o holds at 15. Assert rst_ni=0 with three registers pending -> pend_o=0 immediately (asynchronously).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared widths and index types for the hazard/scoreboard logic beside decode.
package hazard_pkg;

  localparam int REG_W  = 5;
  localparam int LAT_W  = 6;
  localparam int UNIT_W = 1;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [LAT_W-1:0]  lat_t;
  typedef logic [UNIT_W-1:0] unit_idx_t;

endpackage

// File: rtl/sb_counter.sv
// Countdown cell for one scoreboard entry: a load wins over the decrement,
// and the entry is busy/pending while the count is non-zero.
module sb_counter #(
  parameter int W = hazard_pkg::LAT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         nz_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign nz_o = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register/unit scoreboard for multi-cycle units, merged with the single-cycle
// hazard stall so this block is the only stall/flush source for F/D/E.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = hazard_pkg::REG_W,
  parameter int NUM_UNITS = 2,
  parameter int UNIT_W    = hazard_pkg::UNIT_W,
  parameter int LAT_W     = hazard_pkg::LAT_W,
  parameter int PERF_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [REG_W-1:0]     rs_d_i,
  input  logic [REG_W-1:0]     rt_d_i,
  input  logic                 rs_used_d_i,
  input  logic                 rt_used_d_i,
  input  logic                 issue_d_i,
  input  logic [UNIT_W-1:0]    issue_unit_d_i,
  input  logic [LAT_W-1:0]     issue_lat_d_i,
  input  logic [REG_W-1:0]     issue_dst_d_i,
  input  logic                 base_stall_i,
  input  logic                 flush_d_i,
  output logic                 stall_f_o,
  output logic                 stall_d_o,
  output logic                 flush_e_o,
  output logic [NUM_REGS-1:0]  pend_o,
  output logic [NUM_UNITS-1:0] unit_busy_o,
  output logic [PERF_W-1:0]    stall_cnt_o
);

  localparam int REG_SPAN  = 1 << REG_W;
  localparam int UNIT_SPAN = 1 << UNIT_W;

  logic [NUM_REGS-1:0]  pend;
  logic [NUM_UNITS-1:0] busy;
  logic [REG_SPAN-1:0]  pend_ext;
  logic [UNIT_SPAN-1:0] busy_ext;
  logic                 raw_hit;
  logic                 waw_hit;
  logic                 struct_hit;
  logic                 sb_stall;
  logic                 stall;
  logic                 accept;
  logic [PERF_W-1:0]    stall_cnt;

  // Register 0 is hardwired, so it never gets a counter.
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_counter #(.W(LAT_W)) u_reg_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept && (issue_dst_d_i == REG_W'(r))),
      .load_val_i (issue_lat_d_i),
      .nz_o       (pend[r])
    );
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    sb_counter #(.W(LAT_W)) u_unit_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept && (issue_unit_d_i == UNIT_W'(u))),
      .load_val_i (issue_lat_d_i),
      .nz_o       (busy[u])
    );
  end

  // Zero-extended views so out-of-range indices read as "not pending/busy".
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_REGS-1:0] = pend;
    busy_ext = '0;
    busy_ext[NUM_UNITS-1:0] = busy;
  end

  always_comb begin
    raw_hit    = (rs_used_d_i && pend_ext[rs_d_i]) ||
                 (rt_used_d_i && pend_ext[rt_d_i]);
    waw_hit    = issue_d_i && pend_ext[issue_dst_d_i];
    struct_hit = issue_d_i && busy_ext[issue_unit_d_i];
    sb_stall   = raw_hit || waw_hit || struct_hit;
    stall      = sb_stall || base_stall_i;
  end

  // A zero latency marks a single-cycle op; a flushed D never updates state.
  assign accept = issue_d_i && !stall && !flush_d_i && (issue_lat_d_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (sb_stall && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign stall_f_o   = stall;
  assign stall_d_o   = stall;
  assign flush_e_o   = stall;
  assign pend_o      = pend;
  assign unit_busy_o = busy;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default build plus a PERF_W=4 / UNIT_W=2
// build sharing the same stimulus for saturation and untracked-unit cases.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_used;
  logic        rt_used;
  logic        issue;
  logic [1:0]  issue_unit;
  logic [0:0]  issue_unit_big;
  logic [5:0]  issue_lat;
  logic [4:0]  issue_dst;
  logic        base;
  logic        flush;

  logic        b_stall_f, b_stall_d, b_flush_e;
  logic [31:0] b_pend;
  logic [1:0]  b_busy;
  logic [31:0] b_stall_cnt;

  logic        s_stall_f, s_stall_d, s_flush_e;
  logic [31:0] s_pend;
  logic [1:0]  s_busy;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  assign issue_unit_big = issue_unit[0:0];

  hazard_scoreboard u_big (
    .clk_i(clk), .rst_ni(rst_n), .rs_d_i(rs), .rt_d_i(rt),
    .rs_used_d_i(rs_used), .rt_used_d_i(rt_used), .issue_d_i(issue),
    .issue_unit_d_i(issue_unit_big), .issue_lat_d_i(issue_lat),
    .issue_dst_d_i(issue_dst), .base_stall_i(base), .flush_d_i(flush),
    .stall_f_o(b_stall_f), .stall_d_o(b_stall_d), .flush_e_o(b_flush_e),
    .pend_o(b_pend), .unit_busy_o(b_busy), .stall_cnt_o(b_stall_cnt)
  );

  hazard_scoreboard #(.UNIT_W(2), .PERF_W(4)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .rs_d_i(rs), .rt_d_i(rt),
    .rs_used_d_i(rs_used), .rt_used_d_i(rt_used), .issue_d_i(issue),
    .issue_unit_d_i(issue_unit), .issue_lat_d_i(issue_lat),
    .issue_dst_d_i(issue_dst), .base_stall_i(base), .flush_d_i(flush),
    .stall_f_o(s_stall_f), .stall_d_o(s_stall_d), .flush_e_o(s_flush_e),
    .pend_o(s_pend), .unit_busy_o(s_busy), .stall_cnt_o(s_stall_cnt)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       issue;
    logic [1:0] unit;
    logic [4:0] dst;
    logic [5:0] lat;
    logic       base;
    logic       flush;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs = '0; rt = '0; rs_used = 1'b0; rt_used = 1'b0;
    issue = 1'b0; issue_unit = '0; issue_lat = '0; issue_dst = '0;
    base = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present an issue in D for one cycle; it is accepted on that edge unless stalled.
  task automatic drive_issue(input logic [1:0] u, input logic [4:0] d, input logic [5:0] l);
    @(negedge clk);
    issue = 1'b1; issue_unit = u; issue_dst = d; issue_lat = l;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Count cycles the big build stalls on the current D inputs, bounded.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!b_stall_d) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    idle();
    rst_n = 1'b1;

    vecs[0]  = '{"raw_rs",        5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"raw_rs_unused", 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"raw_rt",        5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{"raw_other",     5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"raw_r0",        5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"waw",           5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 5'd8, 6'd3, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"structural",    5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd9, 6'd3, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{"free_issue",    5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 5'd9, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"base_only",     5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"raw_with_flush",5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"dst_no_issue",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 5'd8, 6'd3, 1'b0, 1'b0, 1'b0};

    // Reset held with an issue pending in D
    @(negedge clk);
    rst_n = 1'b0;
    issue = 1'b1; issue_unit = 2'd0; issue_dst = 5'd3; issue_lat = 6'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {b_stall_f, b_stall_d, b_flush_e}, 3'b000);
    check("rst_pend", b_pend, 32'h0);
    check("rst_busy", b_busy, 2'b00);
    check("rst_cnt", b_stall_cnt, 32'h0);
    check("rst_small_pend", s_pend, 32'h0);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_pend", b_pend, 32'h0);
    check("post_rst_cnt", b_stall_cnt, 32'h0);

    // Table vectors against a fixed state: r8 pending, unit 0 busy
    do_reset();
    drive_issue(2'd0, 5'd8, 6'd40);
    check("tbl_setup_pend", b_pend, 32'h0000_0100);
    check("tbl_setup_busy", b_busy, 2'b01);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rs = vecs[i].rs; rt = vecs[i].rt;
      rs_used = vecs[i].rs_used; rt_used = vecs[i].rt_used;
      issue = vecs[i].issue; issue_unit = vecs[i].unit;
      issue_dst = vecs[i].dst; issue_lat = vecs[i].lat;
      base = vecs[i].base; flush = vecs[i].flush;
      #1;
      check({vecs[i].name, "_stall_d"}, b_stall_d, vecs[i].exp_stall);
      check({vecs[i].name, "_stall_f"}, b_stall_f, vecs[i].exp_stall);
      check({vecs[i].name, "_flush_e"}, b_flush_e, vecs[i].exp_stall);
      #1;
      idle();
    end
    check("tbl_end_pend", b_pend, 32'h0000_0100);

    // RAW: lat 4 issue, reader arrives one cycle later and waits three cycles
    do_reset();
    drive_issue(2'd0, 5'd8, 6'd4);
    @(posedge clk);
    #1;
    rs = 5'd8; rs_used = 1'b1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [0:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      check("raw_seq_stall", b_stall_d, e);
      check("raw_seq_pend8", b_pend[8], e);
      if (i < 3) @(posedge clk);
    end
    check("raw_seq_cnt", b_stall_cnt, 32'd3);
    check("raw_seq_small_cnt", s_stall_cnt, 4'd3);
    idle();

    // Structural: second issue to busy unit 1 waits for ucnt to drain
    do_reset();
    drive_issue(2'd1, 5'd5, 6'd6);
    @(negedge clk);
    issue = 1'b1; issue_unit = 2'd1; issue_dst = 5'd9; issue_lat = 6'd3;
    count_stalls(n);
    check("struct_stall_cycles", n, 6);
    @(posedge clk);
    #1;
    idle();
    check("struct_pend9", b_pend[9], 1'b1);
    check("struct_busy", b_busy, 2'b10);

    // WAW: unit 0 is free but r5 is still pending from unit 1
    do_reset();
    drive_issue(2'd1, 5'd5, 6'd6);
    @(negedge clk);
    issue = 1'b1; issue_unit = 2'd0; issue_dst = 5'd5; issue_lat = 6'd2;
    count_stalls(n);
    check("waw_stall_cycles", n, 6);
    @(posedge clk);
    #1;
    idle();
    check("waw_pend5_set", b_pend[5], 1'b1);
    check("waw_busy", b_busy, 2'b01);
    @(posedge clk);
    #1;
    check("waw_pend5_mid", b_pend[5], 1'b1);
    @(posedge clk);
    #1;
    check("waw_pend5_done", b_pend[5], 1'b0);

    // Flush and untracked issues
    do_reset();
    @(negedge clk);
    issue = 1'b1; issue_unit = 2'd0; issue_dst = 5'd7; issue_lat = 6'd5; flush = 1'b1;
    @(posedge clk);
    #1;
    idle();
    check("flush_pend", b_pend, 32'h0);
    check("flush_busy", b_busy, 2'b00);
    drive_issue(2'd0, 5'd7, 6'd0);
    check("lat0_pend", b_pend, 32'h0);
    check("lat0_busy", b_busy, 2'b00);
    drive_issue(2'd0, 5'd0, 6'd5);
    check("dst0_pend", b_pend, 32'h0);
    check("dst0_busy", b_busy, 2'b01);
    @(negedge clk);
    rs = 5'd0; rs_used = 1'b1;
    #1;
    check("dst0_no_stall", b_stall_d, 1'b0);
    idle();

    // Base stall only: outputs follow it, no counting, no accept
    do_reset();
    @(negedge clk);
    base = 1'b1; issue = 1'b1; issue_unit = 2'd1; issue_dst = 5'd7; issue_lat = 6'd5;
    #1;
    check("base_stall", {b_stall_f, b_stall_d, b_flush_e}, 3'b111);
    @(posedge clk);
    #1;
    idle();
    check("base_pend", b_pend, 32'h0);
    check("base_busy", b_busy, 2'b00);
    check("base_cnt", b_stall_cnt, 32'h0);

    // Saturation on the 4-bit counter, then async reset with three pending
    do_reset();
    drive_issue(2'd0, 5'd8, 6'd40);
    @(negedge clk);
    rs = 5'd8; rs_used = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("sat_small_cnt", s_stall_cnt, 4'hf);
    check("sat_big_cnt", b_stall_cnt, 32'd20);
    idle();
    drive_issue(2'd2, 5'd3, 6'd30);
    drive_issue(2'd3, 5'd4, 6'd30);
    drive_issue(2'd2, 5'd6, 6'd30);
    check("three_pend", s_pend, 32'h0000_0158);
    check("untracked_unit_busy", s_busy, 2'b01);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pend", s_pend, 32'h0);
    check("async_rst_busy", s_busy, 2'b00);
    check("async_rst_cnt", s_stall_cnt, 4'h0);
    check("async_rst_big_pend", b_pend, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
